// File: rtl/mem_shadow_responder_pkg.sv
// little_mem_pkg: shared state encoding and word/byte helpers for the shadow responder
package little_mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

    function automatic logic [29:0] word_addr(input logic [31:0] a);
        return a[31:2];
    endfunction

    function automatic logic [31:0] byte_merge(input logic [3:0] wstrb, input logic [31:0] nw, input logic [31:0] old);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b+:8] = wstrb[b] ? nw[8*b+:8] : old[8*b+:8];
        return r;
    endfunction
endpackage

// File: rtl/mem_shadow_responder_if.sv
// mem_shadow_responder_if: core valid/ready memory port
interface mem_shadow_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    modport master (output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata);
    modport slave (input mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_shadow_responder_slot.sv
// mem_shadow_slot: one tracked shadow word with first-touch capture of free data
import little_mem_pkg::*;

module mem_shadow_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        hit,
    input  logic        commit,
    input  logic        capture,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic [31:0] fill,
    output logic [31:0] word,
    output logic        touched
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word    <= '0;
            touched <= 1'b0;
        end else if (hit && commit) begin
            // untouched bytes not covered by the strobe are still unconstrained
            word    <= byte_merge(wstrb, wdata, touched ? word : fill);
            touched <= 1'b1;
        end else if (hit && capture && !touched) begin
            word    <= fill;
            touched <= 1'b1;
        end
    end
endmodule

// File: rtl/mem_shadow_responder.sv
// mem_shadow_responder: bus-side responder with bounded wait states, per-slot shadow words and protocol check
import little_mem_pkg::*;

module mem_shadow_responder #(
    parameter int NUM_SLOTS   = 2,
    parameter int MAX_WAIT    = 4,
    parameter int WAIT_W      = 4,
    parameter int TRACK_INSTR = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SLOTS*32-1:0] slot_addr,
    input  logic [WAIT_W-1:0]       rand_wait,
    input  logic [31:0]             rand_rdata,
    mem_shadow_responder_if.slave   bus,
    output logic [NUM_SLOTS*32-1:0] slot_data,
    output logic [NUM_SLOTS-1:0]    slot_touched,
    output logic                    proto_err
);
    resp_state_t         state;
    logic [WAIT_W-1:0]   cnt, cnt_load;
    logic [31:0]         req_addr, req_wdata, rd;
    logic [3:0]          req_wstrb;
    logic                req_instr, changed, is_resp, is_write;
    logic [NUM_SLOTS-1:0] hit;

    assign cnt_load = rand_wait > WAIT_W'(MAX_WAIT) ? WAIT_W'(MAX_WAIT) : rand_wait;
    assign is_resp  = state == RESP;
    assign is_write = req_wstrb != 4'd0;
    assign changed  = !bus.mem_valid || bus.mem_addr != req_addr || bus.mem_wdata != req_wdata ||
                      bus.mem_wstrb != req_wstrb || bus.mem_instr != req_instr;

    genvar i;
    generate
        for (i = 0; i < NUM_SLOTS; i++) begin : g_slot
            assign hit[i] = word_addr(req_addr) == word_addr(slot_addr[32*i+:32]) && (TRACK_INSTR != 0 || !req_instr);
            mem_shadow_slot u_slot (
                .clk(clk), .reset(reset), .hit(hit[i]),
                .commit(is_resp && is_write), .capture(is_resp && !is_write),
                .wstrb(req_wstrb), .wdata(req_wdata), .fill(rand_rdata),
                .word(slot_data[32*i+:32]), .touched(slot_touched[i])
            );
        end
    endgenerate

    // lowest hitting index wins; scanning downward lets it overwrite higher hits
    always_comb begin
        rd = rand_rdata;
        for (int k = NUM_SLOTS - 1; k >= 0; k--)
            if (hit[k]) rd = slot_touched[k] ? slot_data[32*k+:32] : rand_rdata;
    end

    assign bus.mem_ready = is_resp;
    assign bus.mem_rdata = (is_resp && !is_write) ? rd : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            req_instr <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (state != IDLE && changed) proto_err <= 1'b1;
            case (state)
                IDLE: if (bus.mem_valid) begin
                    req_addr  <= bus.mem_addr;
                    req_wdata <= bus.mem_wdata;
                    req_wstrb <= bus.mem_wstrb;
                    req_instr <= bus.mem_instr;
                    cnt       <= cnt_load;
                    state     <= cnt_load == '0 ? RESP : WAIT;
                end
                WAIT: begin
                    cnt   <= cnt - 1'b1;
                    state <= cnt == WAIT_W'(1) ? RESP : WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_shadow_responder.sv
// tb_mem_shadow_responder: randomized transactions on a tracking and a fetch-filtering responder vs a shadow model
module tb_mem_shadow_responder;
    localparam int MAXW = 4;
    logic        clk = 0, reset = 0;
    logic [63:0] slot_addr;
    logic [3:0]  rand_wait;
    logic [31:0] rand_rdata;
    logic [63:0] sd0, sd1;
    logic [1:0]  st0, st1;
    logic        pe0, pe1;
    int          n_tests = 0, n_fail = 0;

    // shadow model per instance k: k=0 tracks fetches, k=1 does not
    logic [31:0] msh[2][2];
    bit          mtc[2][2];
    bit          mperr;
    logic [31:0] sa[2];

    mem_shadow_responder_if bus();
    mem_shadow_responder_if bus2();
    assign bus2.mem_valid = bus.mem_valid;
    assign bus2.mem_instr = bus.mem_instr;
    assign bus2.mem_addr  = bus.mem_addr;
    assign bus2.mem_wdata = bus.mem_wdata;
    assign bus2.mem_wstrb = bus.mem_wstrb;

    mem_shadow_responder #(.NUM_SLOTS(2), .MAX_WAIT(MAXW), .WAIT_W(4), .TRACK_INSTR(1)) dut (
        .clk(clk), .reset(reset), .slot_addr(slot_addr), .rand_wait(rand_wait), .rand_rdata(rand_rdata),
        .bus(bus), .slot_data(sd0), .slot_touched(st0), .proto_err(pe0));
    mem_shadow_responder #(.NUM_SLOTS(2), .MAX_WAIT(MAXW), .WAIT_W(4), .TRACK_INSTR(0)) dut_ni (
        .clk(clk), .reset(reset), .slot_addr(slot_addr), .rand_wait(rand_wait), .rand_rdata(rand_rdata),
        .bus(bus2), .slot_data(sd1), .slot_touched(st1), .proto_err(pe1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit hits(int k, int i, logic [31:0] a, logic ins);
        return a[31:2] == sa[i][31:2] && (k == 0 || !ins);
    endfunction

    function automatic logic [31:0] model_rd(int k, logic [31:0] a, logic ins, logic [3:0] ws, logic [31:0] r);
        if (ws != 0) return 32'd0;
        for (int i = 0; i < 2; i++) if (hits(k, i, a, ins)) return mtc[k][i] ? msh[k][i] : r;
        return r;
    endfunction

    task automatic model_upd(int k, logic [31:0] a, logic ins, logic [31:0] wd, logic [3:0] ws, logic [31:0] r);
        logic [31:0] base;
        for (int i = 0; i < 2; i++) if (hits(k, i, a, ins)) begin
            if (ws != 0) begin
                base = mtc[k][i] ? msh[k][i] : r;
                for (int b = 0; b < 4; b++) if (ws[b]) base[8*b+:8] = wd[8*b+:8];
                msh[k][i] = base;
                mtc[k][i] = 1;
            end else if (!mtc[k][i]) begin
                msh[k][i] = r;
                mtc[k][i] = 1;
            end
        end
    endtask

    task automatic check_state();
        check("slot_data0", sd0, {msh[0][1], msh[0][0]});
        check("slot_data1", sd1, {msh[1][1], msh[1][0]});
        check("touched0", st0, {mtc[0][1], mtc[0][0]});
        check("touched1", st1, {mtc[1][1], mtc[1][0]});
        check("proto_err0", pe0, mperr);
        check("proto_err1", pe1, mperr);
    endtask

    task automatic do_reset(input logic [31:0] s0, input logic [31:0] s1);
        @(negedge clk);
        reset = 0;
        bus.mem_valid = 0;
        slot_addr = {s1, s0};
        sa[0] = s0; sa[1] = s1;
        for (int k = 0; k < 2; k++) for (int i = 0; i < 2; i++) begin msh[k][i] = 0; mtc[k][i] = 0; end
        mperr = 0;
        @(negedge clk);
        check("rst_ready", {bus.mem_ready, bus2.mem_ready}, 2'b00);
        check("rst_rdata", {bus.mem_rdata, bus2.mem_rdata}, 64'd0);
        check_state();
        reset = 1;
    endtask

    task automatic txn(input logic [31:0] a, input logic ins, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [3:0] w, input logic [31:0] r, input bit glitch);
        int n;
        int lat;
        logic [31:0] e0, e1;
        lat = (int'(w) > MAXW ? MAXW : int'(w)) + 1;
        @(negedge clk);
        bus.mem_valid = 1; bus.mem_addr = a; bus.mem_instr = ins; bus.mem_wdata = wd; bus.mem_wstrb = ws;
        rand_wait = w; rand_rdata = r;
        e0 = model_rd(0, a, ins, ws, r);
        e1 = model_rd(1, a, ins, ws, r);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (glitch && n == 1) bus.mem_valid = 0;
            else if (glitch && n == 2) begin
                bus.mem_valid = 1;
                check("perr_set", {pe0, pe1}, 2'b11);
            end
        end while (!bus.mem_ready && n < 20);
        check("latency", n, lat);
        check("ready_ni", bus2.mem_ready, 1'b1);
        check("rdata0", bus.mem_rdata, e0);
        check("rdata1", bus2.mem_rdata, e1);
        model_upd(0, a, ins, wd, ws, r);
        model_upd(1, a, ins, wd, ws, r);
        if (glitch) mperr = 1;
        @(negedge clk);
        bus.mem_valid = 0;
        rand_rdata = $urandom;
        check("ready_drop", {bus.mem_ready, bus2.mem_ready}, 2'b00);
        check_state();
    endtask

    initial begin
        bus.mem_valid = 0; bus.mem_instr = 0; bus.mem_addr = 0; bus.mem_wdata = 0; bus.mem_wstrb = 0;
        rand_wait = 0; rand_rdata = 0;
        slot_addr = 0;
        do_reset(32'h100, 32'h104);
        txn(32'h100, 0, 0, 4'b0000, 0, 32'hDEADBEEF, 0);
        check("capture_touched", st0[0], 1'b1);
        txn(32'h100, 0, 32'h12345678, 4'b0011, 0, 32'h0BADF00D, 0);
        check("merge_word", sd0[31:0], 32'hDEAD5678);
        txn(32'h100, 0, 0, 4'b0000, 0, 32'h0, 0);
        txn(32'h104, 0, 0, 4'b0000, 3, 32'h01020304, 0);
        txn(32'h104, 0, 32'hCAFEF00D, 4'b1000, 15, 32'h55555555, 0);
        txn(32'h200, 0, 0, 4'b0000, 2, 32'hA5A5A5A5, 0);
        txn(32'h104, 1, 0, 4'b0000, 1, 32'h77777777, 0);
        do_reset(32'h100, 32'h104);
        txn(32'h100, 1, 0, 4'b0000, 0, 32'h13579BDF, 0);
        check("fetch_nocapture", st1, 2'b00);
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            logic [3:0] ws;
            case ($urandom_range(0, 3))
                0: a = 32'h100;
                1: a = 32'h104;
                2: a = 32'h200;
                default: a = 32'h300;
            endcase
            ws = $urandom_range(0, 1) ? 4'($urandom) : 4'd0;
            txn(a, 1'($urandom), $urandom, ws, 4'($urandom_range(0, 15)), $urandom, 0);
        end
        do_reset(32'h40, 32'h40);
        @(negedge clk);
        bus.mem_valid = 1; bus.mem_addr = 32'h40; bus.mem_instr = 0; bus.mem_wdata = 32'hFFFFFFFF; bus.mem_wstrb = 4'hF;
        rand_wait = 4;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        check("midrst_ready", {bus.mem_ready, bus2.mem_ready}, 2'b00);
        check("midrst_data", {sd0, sd1}, 128'd0);
        check("midrst_touched", {st0, st1}, 4'd0);
        bus.mem_valid = 0;
        @(negedge clk);
        reset = 1;
        txn(32'h40, 0, 32'h11223344, 4'hF, 0, 32'h99999999, 0);
        check("dup_data", sd0, {32'h11223344, 32'h11223344});
        check("dup_touched", st0, 2'b11);
        txn(32'h40, 0, 32'hAABBCCDD, 4'b0101, 3, 32'h0, 1);
        txn(32'h40, 0, 0, 4'b0000, 1, 32'h0, 0);
        check("perr_sticky", {pe0, pe1}, 2'b11);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_shadow_responder.md
Name: mem_shadow_responder

Overview:
- Bus-side memory responder and shadow model for the core's valid/ready memory port. Used in formal harnesses and simulation benches.
- Generalises the single-address shadow word to NUM_SLOTS tracked word addresses, each with first-touch capture of free data.
- Drives its own bounded, variable wait states and flags handshake-protocol violations by the core.
- Untracked addresses return unconstrained data from a free input.

Parameters:
- NUM_SLOTS, 2: number of tracked word addresses (1..16).
- MAX_WAIT, 4: maximum wait states inserted before mem_ready (0..15).
- WAIT_W, 4: width of rand_wait; must satisfy 2**WAIT_W > MAX_WAIT.
- TRACK_INSTR, 1: if 1, fetches (mem_instr=1) may hit slots; if 0, fetches never hit.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- slot_addr  input  NUM_SLOTS*32  tracked byte addresses, slot i at [32i+31:32i]; held stable after reset release
- rand_wait  input  WAIT_W  requested wait count, sampled at request accept
- rand_rdata  input  32  free data for untracked reads and first-touch capture
- mem_valid  input  1  core request valid
- mem_instr  input  1  request is an instruction fetch
- mem_addr  input  32  request byte address (word aligned)
- mem_wdata  input  32  write data
- mem_wstrb  input  4  byte write strobes; 0 means read
- mem_ready  output  1  one-cycle response strobe
- mem_rdata  output  32  read data, valid only while mem_ready=1
- slot_data  output  NUM_SLOTS*32  current shadow contents, for checkers
- slot_touched  output  NUM_SLOTS  slot has been captured or written
- proto_err  output  1  sticky handshake-violation flag

Behaviour:
- Reset (async, reset=0): state=IDLE; mem_ready=0; mem_rdata=0; slot_data=0; slot_touched=0; proto_err=0; wait counter=0.
- Match rule: slot i hits when mem_addr[31:2]==slot_addr_i[31:2], and (TRACK_INSTR or !mem_instr). Every hitting slot is updated. Read data comes from the lowest hitting index.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - mem_valid=1: latch addr/wdata/wstrb/instr. Load cnt=min(rand_wait, MAX_WAIT).
  - Next state is RESP if cnt==0, otherwise WAIT.
  - Minimum latency is one cycle: request seen at edge t, mem_ready=1 during cycle t+1.
- WAIT: decrement cnt each cycle; at cnt==1, go to RESP. Total wait states = min(rand_wait, MAX_WAIT). mem_ready never delayed more than MAX_WAIT+1 cycles after accept.
- RESP: mem_ready=1 for exactly one cycle, then IDLE.
  - A request still valid in that cycle is the same transfer. A new request is accepted only from IDLE (the cycle after RESP), so transfers are separated by at least one cycle with mem_ready=0.
- Read (wstrb==0):
  - Hit on a touched slot: return stored word.
  - Hit on an untouched slot: return rand_rdata sampled in the RESP cycle. Store it in every hitting slot and set touched.
  - Miss: return rand_rdata; no state change.
- Write (wstrb!=0), committed on the RESP-cycle edge:
  - Per-byte merge of mem_wdata into each hitting slot.
  - For an untouched slot, non-strobed bytes take rand_rdata bytes.
  - Set touched. mem_rdata=0 during the write response.
- Protocol check:
  - In WAIT or RESP, proto_err is set if mem_valid=0 or any of mem_addr/mem_wdata/mem_wstrb/mem_instr differs from the latched value.
  - Sticky until reset. The responder still completes the latched transfer.
- Reset mid-transfer: abandons the transfer with no slot update; outputs return to reset values immediately.
- mem_valid while in RESP with a changed request counts as a violation per the protocol check above.

Decomposition:
- Shared package little_mem_pkg holds:
  - state enum resp_state_t {IDLE, WAIT, RESP};
  - word-address helper function (addr[31:2]);
  - byte-merge function (wstrb, new, old).
- One natural sub-module, mem_shadow_slot (one per slot, generate loop). It owns the 32-bit word and the touched bit, with inputs hit/commit/capture/wstrb/wdata/fill.
- The top holds the FSM, wait counter, request latch, priority read mux and proto_err.

Test Plan:
- Read then write then read:
  - slot_addr0=0x100, rand_wait=0, rand_rdata=0xDEADBEEF.
  - Read 0x100 -> mem_ready the cycle after accept, mem_rdata=0xDEADBEEF, slot_touched[0]=1.
  - Write 0x12345678, wstrb=4'b0011 -> slot_data0=0xDEAD5678.
  - Reread with rand_rdata=0 -> 0xDEAD5678.
- Wait states:
  - rand_wait=3, MAX_WAIT=4 -> 3 WAIT cycles then mem_ready (ready 4 cycles after accept).
  - rand_wait=15 -> clamped, ready 5 cycles after accept.
- Untracked and fetch filtering:
  - Read 0x200 (miss) -> returns rand_rdata=0xA5A5A5A5, slot_touched unchanged.
  - TRACK_INSTR=0, fetch 0x100 -> miss, no capture.
- Duplicate slots: slot_addr0=slot_addr1=0x40; write 0x11223344 full strobe -> both slots=0x11223344, both touched.
- Protocol violation: during WAIT, drop mem_valid for one cycle -> proto_err=1 next cycle and stays 1. Latched transfer still completes.
- Reset mid-WAIT: assert reset during a write's WAIT -> mem_ready=0 immediately, slot_data unchanged (0), FSM in IDLE after release.
